// File: rtl/radix4_booth_seq_mul.sv
// Sequential radix-4 Booth multiplier: one recoded digit per enabled cycle,
// signed/unsigned operands, valid/ready handshakes on both sides.
module radix4_booth_seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  // state  | meaning
  // S_IDLE | waiting for operands
  // S_MUL  | retiring one Booth digit per enabled cycle
  // S_DONE | product valid, waiting for consumer

  localparam int N  = WIDTH/2 + 1;
  localparam int CW = $clog2(N);
  localparam int XW = WIDTH + 2;
  localparam int AW = WIDTH + 4;

  if ((WIDTH < 4) || (WIDTH % 2 != 0)) begin : g_width_check
    $error("radix4_booth_seq_mul: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [XW-1:0]       r_a;
  logic [XW-1:0]       r_mlt;
  logic                r_prev;
  logic [AW-1:0]       r_acc;
  logic [2*WIDTH-1:0]  r_product;

  logic                w_in_xfer, w_out_xfer, w_last;
  logic [2:0]          w_triplet;
  logic [AW-1:0]       w_ax, w_pp, w_sum, w_acc_nxt;
  logic [XW-1:0]       w_mlt_nxt;

  assign in_ready   = en & ~abort & ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign product    = r_product;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready & en;
  assign w_last     = (r_cnt == CW'(N-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (en) begin
      if (abort) begin
        w_state_nxt = S_IDLE;
      end else begin
        case (r_state)
          S_IDLE:  if (w_in_xfer) w_state_nxt = S_MUL;
          S_MUL:   if (w_last) w_state_nxt = S_DONE;
          S_DONE: begin
            if (w_in_xfer)       w_state_nxt = S_MUL;
            else if (w_out_xfer) w_state_nxt = S_IDLE;
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end
    end
  end

  // Remaining multiplier bits shift out the bottom while settled product bits
  // shift in from the top, so {acc, mlt} holds the full result after N steps.
  assign w_ax      = {{2{r_a[XW-1]}}, r_a};
  assign w_triplet = {r_mlt[1:0], r_prev};

  always_comb begin
    w_pp = '0;
    case (w_triplet)
      3'b001, 3'b010: w_pp = w_ax;
      3'b011:         w_pp = w_ax << 1;
      3'b100:         w_pp = -(w_ax << 1);
      3'b101, 3'b110: w_pp = -w_ax;
      default:        w_pp = '0;
    endcase
  end

  assign w_sum     = r_acc + w_pp;
  assign w_acc_nxt = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
  assign w_mlt_nxt = {w_sum[1:0], r_mlt[XW-1:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_a       <= '0;
      r_mlt     <= '0;
      r_prev    <= 1'b0;
      r_acc     <= '0;
      r_product <= '0;
    end else if (en) begin
      if (abort) begin
        r_cnt <= '0;
      end else if (w_in_xfer) begin
        r_a    <= signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
        r_mlt  <= signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier} : {2'b00, multiplier};
        r_prev <= 1'b0;
        r_acc  <= '0;
        r_cnt  <= '0;
      end else if (r_state == S_MUL) begin
        r_acc  <= w_acc_nxt;
        r_mlt  <= w_mlt_nxt;
        r_prev <= r_mlt[1];
        if (w_last) begin
          r_cnt     <= '0;
          r_product <= {w_acc_nxt[WIDTH-3:0], w_mlt_nxt};
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_radix4_booth_seq_mul.sv
// Bench for radix4_booth_seq_mul: WIDTH 16 directed and random runs, exhaustive
// WIDTH 4 and random WIDTH 32, against a plain integer-arithmetic model.
module tb_radix4_booth_seq_mul;

  logic clk = 1'b0;
  logic rst_n, en, abort, out_ready, signed_mode;

  logic        iv16, ir16, ov16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  logic        iv4, ir4, ov4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        iv32, ir32, ov32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] p32;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] last_exp16;

  always #5 clk = ~clk;

  radix4_booth_seq_mul #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .abort(abort), .in_valid(iv16), .in_ready(ir16),
    .signed_mode(signed_mode), .multiplicand(a16), .multiplier(b16), .out_valid(ov16),
    .out_ready(out_ready), .product(p16), .busy(busy16));

  radix4_booth_seq_mul #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .abort(abort), .in_valid(iv4), .in_ready(ir4),
    .signed_mode(signed_mode), .multiplicand(a4), .multiplier(b4), .out_valid(ov4),
    .out_ready(out_ready), .product(p4), .busy(busy4));

  radix4_booth_seq_mul #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .en(en), .abort(abort), .in_valid(iv32), .in_ready(ir32),
    .signed_mode(signed_mode), .multiplicand(a32), .multiplier(b32), .out_valid(ov32),
    .out_ready(out_ready), .product(p32), .busy(busy32));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: interpret operands as integers, multiply, keep 2*w bits.
  function automatic logic [63:0] ref_mul(input int w, input bit sm,
                                          input logic [31:0] a, input logic [31:0] b);
    longint av, bv;
    logic [63:0] p, mask;
    av = longint'({32'b0, a});
    bv = longint'({32'b0, b});
    if (sm && a[w-1]) av = av - (longint'(1) << w);
    if (sm && b[w-1]) bv = bv - (longint'(1) << w);
    p = 64'(av * bv);
    mask = (w == 32) ? '1 : ((64'd1 << (2*w)) - 64'd1);
    return p & mask;
  endfunction

  task automatic accept16(input bit sm, input logic [15:0] a, input logic [15:0] b);
    int k;
    k = 0;
    signed_mode = sm; a16 = a; b16 = b; iv16 = 1'b1; en = 1'b1;
    while (!ir16 && k < 50) begin tick(); k++; end
    if (!ir16) check("accept16_timeout", 64'd0, 64'd1);
    tick();
    iv16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); signed_mode = 1'($urandom);
  endtask

  task automatic wait_out16(input int stall_at, input int stall_len, output int lat);
    int c;
    c = 0;
    while (!ov16 && c < 200) begin
      en = (stall_len == 0) || !(c >= stall_at && c < stall_at + stall_len);
      tick();
      c++;
    end
    en = 1'b1;
    lat = c;
  endtask

  task automatic op16(input string tag, input bit sm, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] exp, input int exp_lat, input int stall_at, input int stall_len);
    int lat;
    accept16(sm, a, b);
    wait_out16(stall_at, stall_len, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_prod"}, {32'b0, p16}, {32'b0, exp});
    last_exp16 = {32'b0, exp};
  endtask

  task automatic op4(input bit sm, input logic [3:0] a, input logic [3:0] b);
    int k, c;
    k = 0; c = 0;
    signed_mode = sm; a4 = a; b4 = b; iv4 = 1'b1; en = 1'b1; out_ready = 1'b1;
    while (!ir4 && k < 50) begin tick(); k++; end
    tick();
    iv4 = 1'b0;
    while (!ov4 && c < 50) begin tick(); c++; end
    check("w4_lat", 64'(c), 64'd3);
    check("w4_prod", {56'b0, p4}, ref_mul(4, sm, {28'b0, a}, {28'b0, b}));
    tick();
  endtask

  task automatic op32(input bit sm, input logic [31:0] a, input logic [31:0] b);
    int k, c;
    k = 0; c = 0;
    signed_mode = sm; a32 = a; b32 = b; iv32 = 1'b1; en = 1'b1; out_ready = 1'b1;
    while (!ir32 && k < 50) begin tick(); k++; end
    tick();
    iv32 = 1'b0;
    a32 = $urandom;
    while (!ov32 && c < 100) begin tick(); c++; end
    check("w32_lat", 64'(c), 64'd17);
    check("w32_prod", p32, ref_mul(32, sm, a, b));
    tick();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [63:0] q[$];
    int          cyc[$];
    int          nacc, nres, c;
    bit          acc, saw, done;
    logic [63:0] exp;
    bit          sm;
    logic [15:0] ra, rb;

    rst_n = 1'b0; en = 1'b1; abort = 1'b0; out_ready = 1'b1; signed_mode = 1'b0;
    iv16 = 1'b0; a16 = '0; b16 = '0;
    iv4 = 1'b0; a4 = '0; b4 = '0;
    iv32 = 1'b0; a32 = '0; b32 = '0;
    last_exp16 = '0;
    #12;
    check("rst_out_valid", {63'b0, ov16}, 64'd0);
    check("rst_busy", {63'b0, busy16}, 64'd0);
    check("rst_product", {32'b0, p16}, 64'd0);
    #5 rst_n = 1'b1;
    tick();
    check("idle_in_ready", {63'b0, ir16}, 64'd1);

    // Directed corner products
    op16("u_ffff_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 9, 0, 0);
    tick();
    check("drain_out_valid", {63'b0, ov16}, 64'd0);
    check("drain_busy", {63'b0, busy16}, 64'd0);
    op16("s_8000_8000", 1'b1, 16'h8000, 16'h8000, 32'h40000000, 9, 0, 0);
    tick();
    op16("s_ffff_0001", 1'b1, 16'hFFFF, 16'h0001, 32'hFFFFFFFF, 9, 0, 0);
    tick();
    op16("u_0_1234", 1'b0, 16'h0000, 16'h1234, 32'h00000000, 9, 0, 0);
    tick();
    op16("s_8000_7fff", 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, 9, 0, 0);
    tick();

    // Backpressure in DONE
    out_ready = 1'b0;
    op16("bp", 1'b1, 16'h1234, 16'hFEDC, 32'(ref_mul(16, 1'b1, 32'h1234, 32'hFEDC)), 9, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {63'b0, ov16}, 64'd1);
      check("bp_product", {32'b0, p16}, last_exp16);
      check("bp_in_ready", {63'b0, ir16}, 64'd0);
      tick();
    end
    out_ready = 1'b1;
    #0;
    check("bp_release_in_ready", {63'b0, ir16}, 64'd1);
    tick();
    check("bp_release_busy", {63'b0, busy16}, 64'd0);
    check("bp_hold_after_xfer", {32'b0, p16}, last_exp16);

    // Enable stall mid-MUL
    op16("stall", 1'b0, 16'hBEEF, 16'hCAFE, 32'(ref_mul(16, 1'b0, 32'hBEEF, 32'hCAFE)), 12, 4, 3);
    tick();

    // Back-to-back
    q.delete(); cyc.delete();
    nacc = 0; nres = 0; c = 0;
    out_ready = 1'b1; en = 1'b1;
    signed_mode = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom); iv16 = 1'b1;
    while (nres < 4 && c < 200) begin
      acc = iv16 && ir16;
      if (acc) begin
        q.push_back(ref_mul(16, signed_mode, {16'b0, a16}, {16'b0, b16}));
        cyc.push_back(c);
        nacc++;
      end
      if (ov16 && q.size() > 0) begin
        check("b2b_prod", {32'b0, p16}, q.pop_front());
        nres++;
      end
      tick();
      c++;
      if (acc) begin
        if (nacc == 4) iv16 = 1'b0;
        else begin signed_mode = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom); end
      end
    end
    check("b2b_results", 64'(nres), 64'd4);
    if (cyc.size() == 4)
      for (int i = 1; i < 4; i++) check("b2b_period", 64'(cyc[i] - cyc[i-1]), 64'd10);
    tick();
    last_exp16 = {32'b0, p16};
    exp = last_exp16;

    // Abort at iteration 4
    accept16(1'b0, 16'h00FF, 16'h0F0F);
    repeat (4) tick();
    abort = 1'b1;
    #0;
    check("abort_in_ready", {63'b0, ir16}, 64'd0);
    tick();
    abort = 1'b0;
    check("abort_busy", {63'b0, busy16}, 64'd0);
    check("abort_out_valid", {63'b0, ov16}, 64'd0);
    saw = 1'b0;
    repeat (12) begin tick(); if (ov16) saw = 1'b1; end
    check("abort_no_valid", {63'b0, saw}, 64'd0);
    check("abort_prod_hold", {32'b0, p16}, exp);

    // Reset pulse mid-MUL
    accept16(1'b1, 16'h7FFF, 16'h7FFF);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("rstmid_product", {32'b0, p16}, 64'd0);
    check("rstmid_out_valid", {63'b0, ov16}, 64'd0);
    check("rstmid_busy", {63'b0, busy16}, 64'd0);
    #2 rst_n = 1'b1;
    tick();

    // Random WIDTH 16 with stalls and backpressure
    for (int i = 0; i < 40; i++) begin
      sm = 1'($urandom); ra = 16'($urandom); rb = 16'($urandom);
      if (i % 8 == 0) ra = 16'h8000;
      exp = ref_mul(16, sm, {16'b0, ra}, {16'b0, rb});
      accept16(sm, ra, rb);
      done = 1'b0;
      for (int k = 0; k < 400 && !done; k++) begin
        en = ($urandom_range(0, 3) != 0);
        out_ready = 1'($urandom);
        a16 = 16'($urandom);
        if (ov16 && out_ready && en) begin
          check("rand16_prod", {32'b0, p16}, exp);
          done = 1'b1;
        end
        tick();
      end
      if (!done) check("rand16_timeout", 64'd0, 64'd1);
      en = 1'b1; out_ready = 1'b1;
    end

    // Exhaustive WIDTH 4
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          op4(s[0], a[3:0], b[3:0]);

    // Random WIDTH 32 plus extremes
    op32(1'b1, 32'h80000000, 32'h80000000);
    op32(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 0; i < 30; i++) op32(1'($urandom), $urandom, $urandom);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
